store_buffer: RTL and testbench

//  - Posted-write FIFO between the datapath store path (ALUResult/RD2/MemWrite)
//    and DataMemory. Accepts one store per cycle and drains one per cycle into

---
 rtl/store_buffer.sv | 121 ++++++++++++
 tb/tb_store_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// ============================================================================
// Module   : store_buffer
// Posted-write FIFO between the store path and data memory, with youngest-
// entry load forwarding and a flush/drain handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_st_valid,
  input  logic [AW-1:0]            i_st_addr,
  input  logic [DW-1:0]            i_st_data,
  output logic                     o_st_ready,
  input  logic [AW-1:0]            i_ld_addr,
  output logic                     o_ld_hit,
  output logic [DW-1:0]            o_ld_data,
  input  logic                     i_mem_busy,
  output logic                     o_mem_we,
  output logic [AW-1:0]            o_mem_a,
  output logic [DW-1:0]            o_mem_wd,
  input  logic                     i_flush,
  output logic                     o_flush_done,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic          r_flush_done;

  logic          w_nonempty;
  logic          w_push;
  logic          w_pop;
  logic          w_ld_hit;
  logic [DW-1:0] w_ld_data;
  logic [PW-1:0] w_idx;

  assign w_nonempty = (r_count != '0);
  // A full buffer refuses a push even when the head drains this cycle.
  assign o_st_ready = (r_count < CW'(DEPTH)) && (r_state == S_IDLE);
  assign w_push     = i_st_valid & o_st_ready;
  assign w_pop      = w_nonempty & ~i_mem_busy;

  assign o_mem_we     = w_pop;
  assign o_mem_a      = w_nonempty ? r_addr[r_head] : '0;
  assign o_mem_wd     = w_nonempty ? r_data[r_head] : '0;
  assign o_count      = r_count;
  assign o_empty      = ~w_nonempty;
  assign o_flush_done = r_flush_done;
  assign o_ld_hit     = w_ld_hit;
  assign o_ld_data    = w_ld_data;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_ld_hit  = 1'b0;
    w_ld_data = '0;
    w_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == i_ld_addr)) begin
        w_ld_hit  = 1'b1;
        w_ld_data = r_data[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= i_st_addr;
      r_data[r_tail] <= i_st_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= S_IDLE;
      r_flush_done <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count      <= r_count + CW'(w_push) - CW'(w_pop);
      r_flush_done <= 1'b0;
      case (r_state)
        S_IDLE:  if (i_flush) r_state <= S_DRAIN;
        S_DRAIN: begin
          if (r_count == '0) begin
            r_state      <= S_DONE;
            r_flush_done <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module   : tb_store_buffer
// Scoreboarded random and directed bench for store_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_st_valid = 1'b0;
  logic [AW-1:0] i_st_addr = '0;
  logic [DW-1:0] i_st_data = '0;
  logic          o_st_ready;
  logic [AW-1:0] i_ld_addr = '0;
  logic          o_ld_hit;
  logic [DW-1:0] o_ld_data;
  logic          i_mem_busy = 1'b0;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_a;
  logic [DW-1:0] o_mem_wd;
  logic          i_flush = 1'b0;
  logic          o_flush_done;
  logic [2:0]    o_count;
  logic          o_empty;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_st_valid(i_st_valid), .i_st_addr(i_st_addr), .i_st_data(i_st_data),
    .o_st_ready(o_st_ready),
    .i_ld_addr(i_ld_addr), .o_ld_hit(o_ld_hit), .o_ld_data(o_ld_data),
    .i_mem_busy(i_mem_busy), .o_mem_we(o_mem_we), .o_mem_a(o_mem_a), .o_mem_wd(o_mem_wd),
    .i_flush(i_flush), .o_flush_done(o_flush_done),
    .o_count(o_count), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];      // reference buffer contents, oldest first
  ent_t exp_wr[$];  // expected memory writes, in order
  int   fs = 0;     // 0 idle, 1 draining, 2 done
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && (fs == 0);
  endfunction

  // Memory-side monitor: every write strobe must match the next expected store.
  always @(negedge clk) begin
    if (rst_n && o_mem_we) begin
      if (exp_wr.size() == 0) begin
        chk("mem_we_unexpected", 32'(o_mem_we), 32'd0);
      end else begin
        ent_t e;
        e = exp_wr.pop_front();
        chk("mem_a", o_mem_a, e.a);
        chk("mem_wd", o_mem_wd, e.d);
      end
    end
  end

  task automatic model_checks();
    bit          hit;
    logic [31:0] d;
    hit = 1'b0;
    d   = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!hit && mq[i].a == i_ld_addr) begin
        hit = 1'b1;
        d   = mq[i].d;
      end
    end
    chk("st_ready", 32'(o_st_ready), 32'(m_ready()));
    chk("count", 32'(o_count), 32'(mq.size()));
    chk("empty", 32'(o_empty), 32'(mq.size() == 0));
    chk("mem_we", 32'(o_mem_we), 32'((mq.size() != 0) && !i_mem_busy));
    chk("flush_done", 32'(o_flush_done), 32'(fs == 2));
    chk("ld_hit", 32'(o_ld_hit), 32'(hit));
    chk("ld_data", o_ld_data, d);
    if (mq.size() == 0) begin
      chk("mem_a_idle", o_mem_a, 32'd0);
      chk("mem_wd_idle", o_mem_wd, 32'd0);
    end
  endtask

  // One clock: check at negedge, advance the reference at posedge.
  task automatic step();
    bit   push, pop;
    int   fs_n;
    ent_t e;
    @(negedge clk);
    model_checks();
    @(posedge clk);
    push = i_st_valid && m_ready();
    pop  = (mq.size() != 0) && !i_mem_busy;
    fs_n = fs;
    case (fs)
      0: if (i_flush) fs_n = 1;
      1: if (mq.size() == 0) fs_n = 2;
      default: fs_n = 0;
    endcase
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.a = i_st_addr;
      e.d = i_st_data;
      mq.push_back(e);
      exp_wr.push_back(e);
    end
    fs = fs_n;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    i_st_valid = 1'b1;
    i_st_addr  = a;
    i_st_data  = d;
    step();
    i_st_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2;
    chk("rst_mem_we", 32'(o_mem_we), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_st_ready", 32'(o_st_ready), 32'd1);
    chk("rst_ld_hit", 32'(o_ld_hit), 32'd0);
    chk("rst_flush_done", 32'(o_flush_done), 32'd0);
    chk("rst_mem_a", o_mem_a, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Async reset mid-drain with three entries left
    i_mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) store(32'(20 + i), 32'hD000 + 32'(i));
    i_mem_busy = 1'b0;
    step();
    chk("pre_rst_count", 32'(o_count), 32'd3);
    chk("pre_rst_mem_we", 32'(o_mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_we", 32'(o_mem_we), 32'd0);
    chk("arst_count", 32'(o_count), 32'd0);
    chk("arst_empty", 32'(o_empty), 32'd1);
    mq.delete();
    exp_wr.delete();
    fs = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single store, then empty after its drain edge
    store(32'd5, 32'h1234);
    chk("single_mem_we", 32'(o_mem_we), 32'd1);
    chk("single_mem_a", o_mem_a, 32'd5);
    chk("single_mem_wd", o_mem_wd, 32'h1234);
    step();
    chk("single_empty", 32'(o_empty), 32'd1);

    // Full stall: fifth store refused, then in-order drain across the wrap
    i_mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) store(32'(40 + i), 32'hA500 + 32'(i));
    chk("full_count", 32'(o_count), 32'd4);
    chk("full_st_ready", 32'(o_st_ready), 32'd0);
    i_mem_busy = 1'b0;
    idle(5);
    chk("full_drained", 32'(o_empty), 32'd1);

    // Forwarding picks the youngest match
    i_mem_busy = 1'b1;
    store(32'd7, 32'hA);
    store(32'd7, 32'hB);
    store(32'd8, 32'hC);
    i_ld_addr = 32'd7;
    #1;
    chk("fwd_hit7", 32'(o_ld_hit), 32'd1);
    chk("fwd_data7", o_ld_data, 32'hB);
    i_ld_addr = 32'd9;
    #1;
    chk("fwd_hit9", 32'(o_ld_hit), 32'd0);
    chk("fwd_data9", o_ld_data, 32'd0);
    i_ld_addr = 32'd8;
    idle(1);
    i_mem_busy = 1'b0;
    idle(4);

    // Simultaneous push and pop at two entries
    i_mem_busy = 1'b1;
    store(32'd60, 32'h60);
    store(32'd61, 32'h61);
    i_mem_busy = 1'b0;
    store(32'd62, 32'h62);
    chk("pushpop_count", 32'(o_count), 32'd2);
    idle(3);

    // Flush with three entries
    i_mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) store(32'(70 + i), 32'h700 + 32'(i));
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush_st_ready_low", 32'(o_st_ready), 32'd0);
    i_mem_busy = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (o_flush_done) seen = 1'b1;
        else step();
      end
      chk("flush_done_seen", 32'(seen), 32'd1);
    end
    step();
    chk("flush_st_ready_back", 32'(o_st_ready), 32'd1);

    // Flush while empty
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    idle(4);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      i_st_valid = 1'($urandom_range(0, 1));
      i_st_addr  = 32'($urandom_range(0, 7));
      i_st_data  = $urandom;
      i_mem_busy = ($urandom_range(0, 2) == 0);
      i_flush    = ($urandom_range(0, 30) == 0);
      i_ld_addr  = 32'($urandom_range(0, 9));
      step();
    end
    i_st_valid = 1'b0;
    i_mem_busy = 1'b0;
    i_flush    = 1'b0;
    idle(8);
    chk("scoreboard_drained", 32'(exp_wr.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
